// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file writeback path.
package regfile_pkg;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NUM_REGS = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {IDLE, DRAIN, STALL} wb_state_t;
endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Writeback request channel from the execution units (valid/ready).
interface regfile_wb_ctrl_if;
  import regfile_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_addr, output in_data, input in_ready);
  modport slave  (input in_valid, input in_addr, input in_data, output in_ready);
endinterface

// File: rtl/regfile_wb_fifo.sv
// In-order FIFO of writeback entries; exposes entries oldest-first with a valid vector.
module regfile_wb_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           nRESET,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic                           flush_i,
  input  wb_entry_t                      wdata_i,
  output wb_entry_t [DEPTH-1:0]          entry_o,
  output logic [DEPTH-1:0]               valid_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [PW-1:0]         head_q, tail_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_push, do_pop;

  assign do_push = push_i && (count_q < CW'(DEPTH)) && !flush_i;
  assign do_pop  = pop_i && (count_q != '0) && !flush_i;
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (flush_i)
      count_d = '0;
    else if (do_push && !do_pop)
      count_d = count_q + CW'(1);
    else if (do_pop && !do_push)
      count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (flush_i) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (do_push) begin
          mem_q[tail_q] <= wdata_i;
          tail_q        <= tail_q + PW'(1);
        end
        if (do_pop)
          head_q <= head_q + PW'(1);
      end
    end
  end

  // Rotate storage so index 0 is always the head (oldest entry).
  always_comb begin
    entry_o = '0;
    valid_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_o[i] = mem_q[head_q + PW'(i)];
      valid_o[i] = (CW'(i) < count_q);
    end
  end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback front end: buffers requests, drains one per cycle to the register file write port.
// Define REGFILE_WB_BYPASS_EN to add the byp_addr/byp_hit/byp_data forwarding ports.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       nRESET,
  regfile_wb_ctrl_if.slave           req,
  input  logic                       hold,
  input  logic                       flush,
  output logic                       write_enable,
  output logic [ADDR_W-1:0]          write_addr,
  output logic [DATA_W-1:0]          write_data,
  output logic [NUM_REGS-1:0]        pending_mask,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef REGFILE_WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]          byp_addr,
  output logic                       byp_hit,
  output logic [DATA_W-1:0]          byp_data
`endif
);
  localparam int unsigned CW = $clog2(DEPTH+1);

  wb_state_t             state_q, state_d;
  wb_entry_t [DEPTH-1:0] entry;
  logic [DEPTH-1:0]      valid;
  logic [CW-1:0]         count_q;
  logic                  push, pop;
  logic                  we_q, we_d;
  wb_entry_t             out_q, out_d;

  assign req.in_ready = (count_q < CW'(DEPTH)) && !flush;
  assign push         = req.in_valid && req.in_ready;
  assign pop          = (state_q == DRAIN) && (count_q != '0) && !hold && !flush;

  regfile_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .nRESET  (nRESET),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i ({req.in_addr, req.in_data}),
    .entry_o (entry),
    .valid_o (valid),
    .count_o (count_q)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (push) state_d = DRAIN;
      // count_q<=1 with hold low means the last entry pops (or nothing is left).
      DRAIN: if (hold && count_q != '0) state_d = STALL;
             else if (count_q <= CW'(1) && !push) state_d = IDLE;
      STALL: if (!hold) state_d = DRAIN;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    we_d  = pop;
    out_d = pop ? entry[0] : out_q;
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      out_q   <= out_d;
    end
  end

  assign write_enable = we_q;
  assign write_addr   = out_q.addr;
  assign write_data   = out_q.data;
  assign count        = count_q;

  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (valid[i]) pending_mask[entry[i].addr] = 1'b1;
    if (we_q) pending_mask[out_q.addr] = 1'b1;
  end

`ifdef REGFILE_WB_BYPASS_EN
  // Scan oldest to youngest so the youngest match overrides.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    if (we_q && out_q.addr == byp_addr) begin
      byp_hit  = 1'b1;
      byp_data = out_q.data;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i] && entry[i].addr == byp_addr) begin
        byp_hit  = 1'b1;
        byp_data = entry[i].data;
      end
    end
  end
`endif
endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Writer-side front end for the 8x16 register file: accepts writeback requests from execution units over valid/ready, buffers them in a small in-order FIFO, and drains one per cycle onto the register file's write port (write_enable/write_addr/write_data).
- Publishes a pending-write mask so operand readers can stall on registers with writes still in flight.

Parameters:
- DATA_W, 16, write data width; matches register width.
- ADDR_W, 3, register address width (8 registers).
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- in_valid  in  1  writeback request valid.
- in_ready  out  1  request accepted when in_valid & in_ready at a clk edge.
- in_addr  in  ADDR_W  destination register.
- in_data  in  DATA_W  write data.
- hold  in  1  stall the drain; no pop while high.
- flush  in  1  synchronous discard of all pending writes.
- write_enable  out  1  to register file write enable; registered.
- write_addr  out  ADDR_W  to register file write address; registered.
- write_data  out  DATA_W  to register file write data; registered.
- pending_mask  out  2**ADDR_W  bit i=1 while any buffered or outgoing write targets register i.
- count  out  clog2(DEPTH+1)  FIFO occupancy, excluding the output register.

Behaviour:
- Reset, asynchronous on nRESET low:
  - FIFO empty; count=0.
  - write_enable=0, write_addr=0, write_data=0.
  - pending_mask=0; FSM=IDLE.
  - in_ready is 1 once nRESET is high.
- in_ready = (count < DEPTH) & !flush.
  - It depends only on registered count, never on a same-cycle pop.
  - When full, a push is refused even if a pop happens in the same cycle.
- Push: on an edge with in_valid & in_ready, {in_addr, in_data} is written at the tail.
- Pop condition: FSM in DRAIN and count>0 and !hold and !flush.
  - On the pop edge the head moves into the output register and write_enable=1 for exactly the next cycle.
  - Otherwise write_enable=0 on the next cycle; write_addr/write_data keep their last values.
- Latency:
  - A request pushed at edge k into an empty FIFO with hold=0 is popped at edge k+1.
  - write_enable is high in cycle k+1..k+2; the register file captures the write at edge k+2.
  - Peak throughput is one write per cycle.
- Ordering:
  - Strict FIFO order.
  - Multiple writes to the same address are not merged; the last write wins in the register file.
- Simultaneous push and pop: both take effect; count is unchanged.
- Wrap-around: head and tail pointers are ADDR bits of clog2(DEPTH) and wrap modulo DEPTH. Full/empty is decided by count, not by pointer equality.
- FSM states:
  - IDLE: count=0. Go to DRAIN on a push.
  - DRAIN: pop each cycle when allowed.
    - Go to STALL when hold=1 and count>0.
    - Go to IDLE when the last entry pops with no push.
  - STALL: no pop. Return to DRAIN when hold=0.
  - flush from any state: next state IDLE; count=0; pointers reset; next-cycle write_enable=0 (a write already in the output register during the flush cycle still completes); in_data is dropped that cycle.
- pending_mask:
  - Combinational OR of decoded addresses over valid FIFO entries, plus write_addr when write_enable=1.
  - A bit clears in the cycle after the corresponding write_enable cycle, provided no other entry targets that register.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - Adds ports byp_addr (in, ADDR_W), byp_hit (out, 1), byp_data (out, DATA_W).
  - byp_hit=1 when any valid FIFO entry, or the output register while write_enable=1, targets byp_addr.
  - byp_data is the youngest matching entry (tail side first; the output register is the oldest).
  - Purely combinational. byp_data=0 when there is no hit.
- Undefined: ports absent; no bypass logic.

Decomposition:
- Package regfile_pkg:
  - DATA_W=16, ADDR_W=3, NUM_REGS=8.
  - typedef wb_entry_t {addr[ADDR_W], data[DATA_W]}.
  - FSM enum wb_state_t {IDLE, DRAIN, STALL}.
- Sub-module regfile_wb_fifo:
  - Synchronous FIFO of wb_entry_t with push/pop/flush, count, and an entry-valid vector exported for pending_mask and bypass.
  - The top level holds the FSM, output register and mask logic.

Test Plan:
- Reset mid-drain:
  - Stimulus: push 3 entries, drop nRESET low in the middle of the drain.
  - Required: all outputs 0 asynchronously, count=0, pending_mask=0.
  - After release: in_ready=1.
- Single write latency:
  - Stimulus: push (addr=5, data=16'hA5A5) at edge k, hold=0.
  - Required: write_enable=1, write_addr=5, write_data=16'hA5A5 in cycle k+1 only.
  - pending_mask=8'b0010_0000 from k to k+2, then 0.
- Full and wrap:
  - Stimulus: hold=1, push 4 entries (addr 0..3). Then push with in_valid=1.
  - Required: in_ready=0, count=4, pending_mask=8'h0F.
  - Then release hold, keep pushing addr 4..7.
  - Required: writes emerge in order 0..7, one per cycle after the first pop; pointers wrap with no loss.
- Hold stall:
  - Stimulus: raise hold for 3 cycles during a drain of 2 entries.
  - Required: no write_enable during hold; FSM in STALL; entries resume in order after hold=0.
- Flush:
  - Stimulus: 3 entries pending plus a concurrent push, then flush=1 for one cycle.
  - Required: push refused; next cycle count=0, write_enable=0, pending_mask=0; FSM=IDLE.
- Bypass (REGFILE_WB_BYPASS_EN):
  - Stimulus: hold=1, push (2,16'h1111) then (2,16'h2222); set byp_addr=2.
  - Required: byp_hit=1, byp_data=16'h2222.
  - With byp_addr=6: byp_hit=0, byp_data=0.
